noc_host_ctrl: RTL and testbench

NOC_HOST_CTRL -- requirements
Module: noc_host_ctrl

---
 rtl/noc_host_ctrl.sv | 147 ++++++++++++++
 tb/tb_noc_host_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/noc_host_ctrl.sv
// Host-side task controller for a NoC node: handshake, start, completion, timeout.
// Define NOC_HOST_SYNC_EN to add two-flop synchronizers on the node inputs.
module noc_host_ctrl #(
  parameter int TMO_W = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [5:0] cmd_dst_seq,
  input  logic [1:0] cmd_send_flag,
  input  logic [1:0] cmd_recv_flag,
  input  logic       flush,
  output logic [5:0] si_dst_seq,
  output logic [1:0] send_finish_flag,
  output logic [1:0] receive_finish_flag,
  output logic       start_in,
  input  logic       start_out,
  input  logic       task_send_finish_lc,
  input  logic       task_receive_finish_lc,
  output logic       done_valid,
  output logic [1:0] done_status,
  output logic [7:0] task_count
);

  typedef enum logic [2:0] {
    IDLE, SETUP, START, WAIT_FIN, DONE
  } state_t;

  localparam logic [1:0] ST_OK    = 2'b00;
  localparam logic [1:0] ST_TMO   = 2'b01;
  localparam logic [1:0] ST_FLUSH = 2'b10;

  // Last timer value before the limit: the move to DONE happens as it wraps to limit.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_t           state;
  logic [TMO_W-1:0] timer;
  logic             snd_sticky;
  logic             rcv_sticky;
  logic             ack;
  logic             snd_fin;
  logic             rcv_fin;

`ifdef NOC_HOST_SYNC_EN
  logic [2:0] sync1;
  logic [2:0] sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {start_out, task_send_finish_lc, task_receive_finish_lc};
      sync2 <= sync1;
    end
  end

  assign {ack, snd_fin, rcv_fin} = sync2;
`else
  assign ack     = start_out;
  assign snd_fin = task_send_finish_lc;
  assign rcv_fin = task_receive_finish_lc;
`endif

  logic snd_seen;
  logic rcv_seen;
  logic tmo_hit;

  assign snd_seen  = snd_sticky | snd_fin;
  assign rcv_seen  = rcv_sticky | rcv_fin;
  assign tmo_hit   = (timer == TMO_LAST);
  assign cmd_ready = (state == IDLE) && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= IDLE;
      timer               <= '0;
      snd_sticky          <= 1'b0;
      rcv_sticky          <= 1'b0;
      start_in            <= 1'b0;
      done_valid          <= 1'b0;
      done_status         <= ST_OK;
      task_count          <= '0;
      si_dst_seq          <= '0;
      send_finish_flag    <= '0;
      receive_finish_flag <= '0;
    end else begin
      done_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            si_dst_seq          <= cmd_dst_seq;
            send_finish_flag    <= cmd_send_flag;
            receive_finish_flag <= cmd_recv_flag;
            timer               <= '0;
            snd_sticky          <= 1'b0;
            rcv_sticky          <= 1'b0;
            state               <= SETUP;
          end
        end
        SETUP: begin
          if (flush) begin
            state       <= DONE;
            done_valid  <= 1'b1;
            done_status <= ST_FLUSH;
          end else begin
            state    <= START;
            start_in <= 1'b1;
          end
        end
        START, WAIT_FIN: begin
          snd_sticky <= snd_seen;
          rcv_sticky <= rcv_seen;
          timer      <= timer + 1'b1;
          if (flush) begin
            state       <= DONE;
            start_in    <= 1'b0;
            done_valid  <= 1'b1;
            done_status <= ST_FLUSH;
          end else if (state == WAIT_FIN && snd_seen && rcv_seen) begin
            state       <= DONE;
            done_valid  <= 1'b1;
            done_status <= ST_OK;
            task_count  <= task_count + 8'd1;
          end else if (tmo_hit) begin
            state       <= DONE;
            start_in    <= 1'b0;
            done_valid  <= 1'b1;
            done_status <= ST_TMO;
          end else if (state == START && ack) begin
            state    <= WAIT_FIN;
            start_in <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          start_in <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_noc_host_ctrl.sv
// Self-checking bench for noc_host_ctrl: directed scenarios plus randomized tasks
// checked against a timeline model of when each task must finish and why.
module tb_noc_host_ctrl;

  localparam int TMO_W = 4;
  localparam int LIM   = (1 << TMO_W) - 1;
  localparam int NONE  = 999;
`ifdef NOC_HOST_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [5:0] cmd_dst_seq;
  logic [1:0] cmd_send_flag;
  logic [1:0] cmd_recv_flag;
  logic       flush;
  logic [5:0] si_dst_seq;
  logic [1:0] send_finish_flag;
  logic [1:0] receive_finish_flag;
  logic       start_in;
  logic       start_out;
  logic       task_send_finish_lc;
  logic       task_receive_finish_lc;
  logic       done_valid;
  logic [1:0] done_status;
  logic [7:0] task_count;

  int checks = 0;
  int errors = 0;
  int model_count = 0;

  noc_host_ctrl #(.TMO_W(TMO_W)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .cmd_valid              (cmd_valid),
    .cmd_ready              (cmd_ready),
    .cmd_dst_seq            (cmd_dst_seq),
    .cmd_send_flag          (cmd_send_flag),
    .cmd_recv_flag          (cmd_recv_flag),
    .flush                  (flush),
    .si_dst_seq             (si_dst_seq),
    .send_finish_flag       (send_finish_flag),
    .receive_finish_flag    (receive_finish_flag),
    .start_in               (start_in),
    .start_out              (start_out),
    .task_send_finish_lc    (task_send_finish_lc),
    .task_receive_finish_lc (task_receive_finish_lc),
    .done_valid             (done_valid),
    .done_status            (done_status),
    .task_count             (task_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    cmd_valid              = 1'b0;
    flush                  = 1'b0;
    start_out              = 1'b0;
    task_send_finish_lc    = 1'b0;
    task_receive_finish_lc = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if ({start_in, done_valid, si_dst_seq, send_finish_flag,
         receive_finish_flag, done_status, task_count} !== 21'd0
        || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s: ready=%b start=%b dv=%b seq=%h sf=%b rf=%b st=%b cnt=%0d, need ready=1 rest 0",
               tag, cmd_ready, start_in, done_valid, si_dst_seq, send_finish_flag,
               receive_finish_flag, done_status, task_count);
    end
  endtask

  // Inputs a/s/r/f are cycles (relative to the accept cycle 0) at which
  // start_out, send finish, receive finish and flush pulse; NONE = never.
  task automatic run_task(input string tag, input int a, input int s, input int r,
                          input int f, input logic [5:0] dst,
                          input logic [1:0] sf, input logic [1:0] rf);
    int ae, c, dcomp, d, start_end;
    logic [1:0] st;
    ae = a + LAT;
    c  = ((s > r) ? s : r) + LAT;
    dcomp = (c <= ae) ? ae + 2 : c + 1;
    if (dcomp <= 2 + LIM) begin
      d = dcomp; st = 2'b00;
    end else begin
      d = 2 + LIM; st = 2'b01;
    end
    if (f <= d - 1) begin
      d = f + 1; st = 2'b10;
    end
    start_end = (ae < d - 1) ? ae : d - 1;
    if (st == 2'b00) model_count = (model_count + 1) % 256;

    cmd_valid     = 1'b1;
    cmd_dst_seq   = dst;
    cmd_send_flag = sf;
    cmd_recv_flag = rf;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept: cmd_ready=%b need 1", tag, cmd_ready);
    end
    tick();
    cmd_valid     = 1'b0;
    cmd_dst_seq   = 6'($urandom);
    cmd_send_flag = 2'($urandom);
    cmd_recv_flag = 2'($urandom);
    for (int cyc = 1; cyc <= d; cyc++) begin
      start_out              = (cyc == a);
      task_send_finish_lc    = (cyc == s);
      task_receive_finish_lc = (cyc == r);
      flush                  = (cyc == f);
      @(negedge clk);
      checks++;
      if (start_in !== (cyc >= 2 && cyc <= start_end)) begin
        errors++;
        $display("FAIL %s start_in c%0d: got %b need %b", tag, cyc, start_in,
                 (cyc >= 2 && cyc <= start_end));
      end
      checks++;
      if (done_valid !== (cyc == d)) begin
        errors++;
        $display("FAIL %s done_valid c%0d: got %b need %b", tag, cyc, done_valid, (cyc == d));
      end
      if (cyc == d) begin
        checks++;
        if (done_status !== st || task_count !== 8'(model_count)) begin
          errors++;
          $display("FAIL %s result: status=%b cnt=%0d need status=%b cnt=%0d",
                   tag, done_status, task_count, st, model_count);
        end
        checks++;
        if (si_dst_seq !== dst || send_finish_flag !== sf || receive_finish_flag !== rf) begin
          errors++;
          $display("FAIL %s hold: seq=%h sf=%b rf=%b need %h %b %b",
                   tag, si_dst_seq, send_finish_flag, receive_finish_flag, dst, sf, rf);
        end
      end
      tick();
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || done_valid !== 1'b0 || done_status !== st || start_in !== 1'b0) begin
      errors++;
      $display("FAIL %s after: ready=%b dv=%b status=%b start=%b need 1 0 %b 0",
               tag, cmd_ready, done_valid, done_status, start_in, st);
    end
    tick();
  endtask

  task automatic test_reset();
    clear_inputs();
    cmd_dst_seq = '0; cmd_send_flag = '0; cmd_recv_flag = '0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("reset");
    tick();
  endtask

  task automatic test_normal();
    run_task("normal", 4, 9, 12, NONE, 6'h2A, 2'b01, 2'b10);
  endtask

  task automatic test_timeout();
    run_task("timeout", NONE, NONE, NONE, NONE, 6'h11, 2'b11, 2'b00);
  endtask

  task automatic test_flush();
    run_task("flush_wait", 4, NONE, NONE, 8, 6'h05, 2'b10, 2'b01);
    run_task("flush_setup", 4, 6, 7, 1, 6'h3F, 2'b11, 2'b11);
  endtask

  task automatic test_same_cycle();
    run_task("same_a", 4, 1 + LIM - LAT, 1 + LIM - LAT, NONE, 6'h15, 2'b01, 2'b01);
    run_task("same_b", 4, 1 + LIM - LAT, 1 + LIM - LAT, 1 + LIM, 6'h2B, 2'b10, 2'b10);
  endtask

  task automatic test_idle_flush();
    flush = 1'b1;
    cmd_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush ready: got %b need 0", cmd_ready);
    end
    tick();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b0 || done_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush hold: ready=%b dv=%b need 0 0", cmd_ready, done_valid);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || start_in !== 1'b0) begin
      errors++;
      $display("FAIL idle_flush release: ready=%b start=%b need 1 0", cmd_ready, start_in);
    end
    tick();
  endtask

  task automatic test_random();
    int a, s, r, f;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(2, 18));
      s = int'($urandom_range(2, 20));
      r = int'($urandom_range(2, 20));
      f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 18)) : NONE;
      run_task("random", a, s, r, f, 6'($urandom), 2'($urandom), 2'($urandom));
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_dst_seq = 6'h33; cmd_send_flag = 2'b11; cmd_recv_flag = 2'b01;
    tick();
    cmd_valid = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (start_in !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid start: got %b need 1", start_in);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_count = 0;
    @(negedge clk);
    check_reset_vals("reset_mid");
    tick();
    run_task("post_reset", 3, 5, 6, NONE, 6'h01, 2'b01, 2'b10);
  endtask

  initial begin
    rst = 1'b1;
    test_reset();
    test_normal();
    test_timeout();
    test_flush();
    test_same_cycle();
    test_idle_flush();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
